// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand feeder for a DIMxDIM systolic array (A rows / B columns, skewed)
//
// Holds one A and one B matrix, loaded a row at a time while idle. A start
// pulse launches a 3*DIM-2 cycle stream in which row i of A and column j of B
// are delayed by i and j cycles respectively, padded with zeros, with mac_en
// high for the whole stream so the array accumulates C = A*B.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en/wr_sel  row write strobe; wr_sel 0 = A buffer, 1 = B buffer
//   wr_row        row index written
//   wr_data       row contents, element j -> column j
//   start         launch a stream (only honoured in IDLE)
//   A_out         skewed A vector, element i feeds array row i
//   B_out         skewed B vector, element j feeds array column j
//   mac_en        array accumulate enable, high for each stream cycle
//   busy          high while streaming
//   done          single-cycle pulse in the first idle cycle after a stream

module systolic_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int CNT_W   = $clog2(3*DIM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [$clog2(DIM)-1:0]            wr_row,
  input  logic signed [DIM-1:0][BITS_AB-1:0] wr_data,
  input  logic                              start,
  output logic signed [DIM-1:0][BITS_AB-1:0] A_out,
  output logic signed [DIM-1:0][BITS_AB-1:0] B_out,
  output logic                              mac_en,
  output logic                              busy,
  output logic                              done
);

  localparam int                      IDX_W  = $clog2(DIM);
  localparam logic [CNT_W-1:0]        LAST   = CNT_W'(3*DIM-3);
  localparam logic signed [CNT_W:0]   DIM_S  = (CNT_W+1)'(DIM);
  localparam logic signed [CNT_W:0]   ZERO_S = '0;

  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [DIM-1:0][BITS_AB-1:0] row_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_d;
  logic               mac_en_q, busy_q, done_q;
  row_t               a_q [DIM];
  row_t               b_q [DIM];
  row_t               a_d [DIM];
  row_t               b_d [DIM];
  row_t               a_out_q, a_out_d;
  row_t               b_out_q, b_out_d;
  logic signed [CNT_W:0] diff;

  // Buffer image after this edge's write. Outputs for stream cycle 0 are
  // computed from it, so a write coincident with start is already visible.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == IDLE && wr_en) begin
      if (wr_sel) b_d[wr_row] = wr_data;
      else        a_d[wr_row] = wr_data;
    end
  end

  // cnt_q is the stream cycle currently presented on the outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = STREAM;
      end
      STREAM: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skew: lane k carries element (t-k) of its row/column. The difference is
  // taken one bit wider and signed so negative offsets never alias.
  always_comb begin
    diff    = '0;
    a_out_d = '0;
    b_out_d = '0;
    if (state_d == STREAM) begin
      for (int k = 0; k < DIM; k++) begin
        diff = $signed({1'b0, cnt_d}) - $signed((CNT_W+1)'(k));
        if (diff >= ZERO_S && diff < DIM_S) begin
          a_out_d[k] = a_d[k][diff[IDX_W-1:0]];
          b_out_d[k] = b_d[diff[IDX_W-1:0]][k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      a_out_q  <= '0;
      b_out_q  <= '0;
      mac_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
      mac_en_q <= (state_d == STREAM);
      busy_q   <= (state_d == STREAM);
      done_q   <= done_d;
    end
  end

  assign A_out  = a_out_q;
  assign B_out  = b_out_q;
  assign mac_en = mac_en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
